// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - beat-aligned LFSR note generator for the light row
//
// Ports:
//   clk        system clock, all state changes on posedge
//   reset      asynchronous active-low reset
//   enable     game running (level)
//   stop       score saturated; forces HALT (priority over enable)
//   density    note threshold 0..7, only looked at on a decision boundary
//   note       light row start input, held for a whole beat per issued note
//   beat       high on the last cycle of each beat
//   notes_sent saturating count of issued notes

module note_sequencer #(
    parameter int          BEAT_CYCLES = 16,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    parameter int          MIN_GAP     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       stop,
    input  logic [2:0] density,
    output logic       note,
    output logic       beat,
    output logic [7:0] notes_sent
);

    localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [CW-1:0] LAST     = CW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] counter;
    logic [7:0]    lfsr, lfsr_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic          note_nxt;
    logic [7:0]    sent_nxt;
    logic          boundary;
    logic          decide;
    logic          issue;

    assign boundary = (counter == LAST);

    // Beat counter free-runs in every state so beats stay phase-aligned
    // with the light row, which leaves reset at the same time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
        end else if (boundary) begin
            counter <= '0;
        end else begin
            counter <= counter + CW'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; stop outranks enable everywhere
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (boundary && enable && !stop) state_nxt = RUN;
            RUN: begin
                if (stop)         state_nxt = HALT;
                else if (!enable) state_nxt = IDLE;
            end
            HALT: if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath logic. A decision happens on a boundary whenever we
    // end up in RUN: either staying there or entering from IDLE.
    always_comb begin
        decide   = boundary && enable && !stop && (state != HALT);
        issue    = decide && (gap_cnt == '0) && (lfsr[2:0] < density);

        note_nxt = note;
        if (state_nxt != RUN) begin
            note_nxt = 1'b0;
        end else if (decide) begin
            note_nxt = issue;
        end

        lfsr_nxt = lfsr;
        if (decide) begin
            lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end

        gap_nxt = gap_cnt;
        if (issue) begin
            gap_nxt = GAP_LOAD;
        end else if (decide && gap_cnt != '0) begin
            gap_nxt = gap_cnt - GW'(1);
        end

        sent_nxt = notes_sent;
        if (issue && notes_sent != 8'hFF) begin
            sent_nxt = notes_sent + 8'd1;
        end

        beat = boundary;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note       <= 1'b0;
            lfsr       <= LFSR_SEED;
            gap_cnt    <= '0;
            notes_sent <= 8'd0;
        end else begin
            note       <= note_nxt;
            lfsr       <= lfsr_nxt;
            gap_cnt    <= gap_nxt;
            notes_sent <= sent_nxt;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer

module tb_note_sequencer;

    localparam int BEAT = 16;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] density = 3'd0;
    logic       note_a, beat_a, note_b, beat_b;
    logic [7:0] sent_a, sent_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    note_sequencer dut_a (
        .clk(clk), .reset(reset), .enable(enable), .stop(stop),
        .density(density), .note(note_a), .beat(beat_a), .notes_sent(sent_a)
    );

    note_sequencer #(.MIN_GAP(0)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .stop(stop),
        .density(density), .note(note_b), .beat(beat_b), .notes_sent(sent_b)
    );

    // Reference model: one entry per instance, described by the game rules
    int       m_cyc;
    int       mode[2];
    bit [7:0] mlfsr[2];
    int       mgap[2];
    bit       mnote[2];
    int       msent[2];
    int       mg[2] = '{1, 0};

    function automatic bit [7:0] lfsr_step(bit [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    task automatic model_reset();
        m_cyc = 0;
        for (int i = 0; i < 2; i++) begin
            mode[i] = M_IDLE; mlfsr[i] = 8'hA5; mgap[i] = 0;
            mnote[i] = 1'b0; msent[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit bnd;
        bit iss;
        bnd = (m_cyc == BEAT - 1);
        for (int i = 0; i < 2; i++) begin
            if (mode[i] == M_RUN && stop) begin
                mode[i] = M_HALT; mnote[i] = 1'b0;
            end else if (mode[i] == M_RUN && !enable) begin
                mode[i] = M_IDLE; mnote[i] = 1'b0;
            end else if (mode[i] == M_HALT) begin
                if (!enable) mode[i] = M_IDLE;
            end else if (bnd && enable && !stop) begin
                mode[i] = M_RUN;
                iss = (mgap[i] == 0) && (int'(mlfsr[i] % 8) < int'(density));
                mnote[i] = iss;
                if (iss) begin
                    mgap[i] = mg[i];
                    if (msent[i] < 255) msent[i]++;
                end else if (mgap[i] > 0) begin
                    mgap[i]--;
                end
                mlfsr[i] = lfsr_step(mlfsr[i]);
            end
        end
        m_cyc = (m_cyc + 1) % BEAT;
    endtask

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("note_a", note_a, mnote[0]);
        chk("beat_a", beat_a, (m_cyc == BEAT - 1));
        chk("sent_a", sent_a, msent[0]);
        chk("note_b", note_b, mnote[1]);
        chk("beat_b", beat_b, (m_cyc == BEAT - 1));
        chk("sent_b", sent_b, msent[1]);
    endtask

    // Inputs change at posedge+1; outputs are sampled at posedge+1 too.
    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        step();
        step();
        reset = 1'b1;
    endtask

    typedef struct {
        bit       rst;
        bit       en;
        bit       stp;
        bit [2:0] dens;
        int       cycles;
        bit       e_note;
        bit       e_beat;
        int       e_sent;
        string    name;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int consec;
        bit prev_note;

        // Cycle k after reset release is the cycle with counter == k % 16.
        tbl.push_back('{1, 1, 0, 3'd7,    0, 0, 0, 0, "reset_state"});
        tbl.push_back('{0, 1, 0, 3'd7,   15, 0, 1, 0, "cyc15_beat"});
        tbl.push_back('{0, 1, 0, 3'd7,    1, 1, 0, 1, "cyc16_first_note"});
        tbl.push_back('{0, 1, 0, 3'd7,   15, 1, 1, 1, "cyc31_held"});
        tbl.push_back('{0, 1, 0, 3'd7,    1, 0, 0, 1, "cyc32_gap"});
        tbl.push_back('{0, 1, 0, 3'd7,   15, 0, 1, 1, "cyc47_beat"});
        tbl.push_back('{0, 1, 0, 3'd7,    1, 1, 0, 2, "cyc48_note"});
        tbl.push_back('{0, 1, 0, 3'd7,    4, 1, 0, 2, "cyc52_held"});
        tbl.push_back('{0, 1, 1, 3'd7,    1, 0, 0, 2, "stop_clears"});
        tbl.push_back('{0, 1, 0, 3'd7,  128, 0, 0, 2, "halt_8_beats"});
        tbl.push_back('{0, 0, 0, 3'd7,    1, 0, 0, 2, "halt_to_idle"});
        tbl.push_back('{0, 1, 0, 3'd7,   10, 0, 0, 2, "resume_gap"});
        tbl.push_back('{0, 1, 0, 3'd7,   16, 1, 0, 3, "resume_note"});
        tbl.push_back('{1, 1, 0, 3'd5,   16, 0, 0, 0, "density5_no_note"});
        tbl.push_back('{0, 1, 0, 3'd0, 1024, 0, 0, 0, "density0_64_beats"});

        foreach (tbl[k]) begin
            enable  = tbl[k].en;
            stop    = tbl[k].stp;
            density = tbl[k].dens;
            if (tbl[k].rst) do_reset();
            for (int c = 0; c < tbl[k].cycles; c++) step();
            chk({tbl[k].name, "_note"}, note_a, tbl[k].e_note);
            chk({tbl[k].name, "_beat"}, beat_a, tbl[k].e_beat);
            chk({tbl[k].name, "_sent"}, sent_a, tbl[k].e_sent);
        end

        // Asynchronous reset in the middle of a note beat
        enable = 1'b1; stop = 1'b0; density = 3'd7;
        do_reset();
        for (int c = 0; c < 20; c++) step();
        chk("pre_reset_note", note_a, 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_reset_note", note_a, 0);
        chk("async_reset_sent", sent_a, 0);
        step();
        reset = 1'b1;
        for (int c = 0; c < 15; c++) step();
        chk("restart_beat", beat_a, 1);
        chk("restart_note", note_a, 0);
        step();
        chk("restart_first_note", note_a, 1);

        // Saturation with back-to-back notes on the MIN_GAP=0 instance
        do_reset();
        consec = 0;
        prev_note = 1'b0;
        for (int c = 0; c < 300 * BEAT; c++) begin
            step();
            if (m_cyc == 0) begin
                if (prev_note && note_b) consec = 1;
                prev_note = note_b;
            end
        end
        chk("sat_sent_b", sent_b, 255);
        chk("consecutive_notes", consec, 1);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset   = 1'b1;
            enable  = ($urandom_range(0, 99) < 90);
            stop    = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 15) == 0) density = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                model_reset();
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
